// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - SHORT/LONG/DOUBLE button gesture classifier with one-deep event register
// Optional feature: BTN_EVENT_DOUBLE_EN builds DOUBLE detection (WAIT_SECOND / SECOND_PRESSED).
module button_event_ctrl #(
  parameter int unsigned clock_freq      = 100_000_000,
  parameter int unsigned long_press_ms   = 1000,
  parameter int unsigned double_click_ms = 300,
  parameter logic        initial_value   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_i,
  output logic       event_valid_o,
  output logic [1:0] event_code_o,
  input  logic       event_ready_i,
  output logic       overrun_o
);

  localparam int unsigned PRESC_MAX = clock_freq / 1000 - 1;
  localparam int unsigned PW        = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
`ifdef BTN_EVENT_DOUBLE_EN
  localparam int unsigned MS_MAX    = (long_press_ms > double_click_ms) ? long_press_ms : double_click_ms;
`else
  localparam int unsigned MS_MAX    = long_press_ms;
`endif
  localparam int unsigned MW        = $clog2(MS_MAX + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_MAX);
  localparam logic [MW-1:0] MS_SAT     = MW'(MS_MAX);
  localparam logic [MW-1:0] LONG_LAST  = MW'(long_press_ms - 1);
`ifdef BTN_EVENT_DOUBLE_EN
  localparam logic [MW-1:0] DBL_LAST   = MW'(double_click_ms - 1);
`endif

  localparam logic [1:0] CODE_SHORT  = 2'b01;
  localparam logic [1:0] CODE_LONG   = 2'b10;
`ifdef BTN_EVENT_DOUBLE_EN
  localparam logic [1:0] CODE_DOUBLE = 2'b11;
`endif

  typedef enum logic [2:0] {
    S_HOLD_OFF,
    S_IDLE,
    S_PRESSED,
`ifdef BTN_EVENT_DOUBLE_EN
    S_WAIT_SECOND,
    S_SECOND_PRESSED,
`endif
    S_LONG_HELD
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [MW-1:0] ms_cnt_q, ms_cnt_d;
  logic          valid_q, valid_d;
  logic [1:0]    code_q, code_d;
  logic          overrun_q, overrun_d;

  logic          active;
  logic          ms_tick;
  logic          long_hit;
  logic          emit;
  logic [1:0]    emit_code;
  logic          load;

  assign active   = (btn_i != initial_value);
  assign ms_tick  = (presc_q == PRESC_LAST);
  // Timers fire on the tick that would carry ms_cnt up to the limit, so the
  // event edge lands exactly limit*clock_freq/1000 cycles after state entry.
  assign long_hit = ms_tick && (ms_cnt_q == LONG_LAST);

  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_code = 2'b00;
    case (state_q)
      S_HOLD_OFF: begin
        if (!active) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (active) state_d = S_PRESSED;
      end
      S_PRESSED: begin
        if (long_hit) begin
          emit      = 1'b1;
          emit_code = CODE_LONG;
          state_d   = S_LONG_HELD;
        end else if (!active) begin
`ifdef BTN_EVENT_DOUBLE_EN
          state_d   = S_WAIT_SECOND;
`else
          emit      = 1'b1;
          emit_code = CODE_SHORT;
          state_d   = S_IDLE;
`endif
        end
      end
      S_LONG_HELD: begin
        if (!active) state_d = S_IDLE;
      end
`ifdef BTN_EVENT_DOUBLE_EN
      S_WAIT_SECOND: begin
        if (active) begin
          state_d = S_SECOND_PRESSED;
        end else if (ms_tick && (ms_cnt_q == DBL_LAST)) begin
          emit      = 1'b1;
          emit_code = CODE_SHORT;
          state_d   = S_IDLE;
        end
      end
      S_SECOND_PRESSED: begin
        if (!active) begin
          emit      = 1'b1;
          emit_code = CODE_DOUBLE;
          state_d   = S_IDLE;
        end
      end
`endif
      default: state_d = S_HOLD_OFF;
    endcase
  end

  always_comb begin
    presc_d  = '0;
    ms_cnt_d = '0;
    if (state_d == state_q) begin
      presc_d  = ms_tick ? '0 : presc_q + PW'(1);
      ms_cnt_d = ms_cnt_q;
      if (ms_tick && (ms_cnt_q != MS_SAT)) ms_cnt_d = ms_cnt_q + MW'(1);
    end
  end

  // A held event that is being accepted this cycle frees the slot for a new one.
  assign load = emit && (!valid_q || event_ready_i);

  always_comb begin
    valid_d   = valid_q;
    code_d    = code_q;
    overrun_d = overrun_q;
    if (load) begin
      valid_d = 1'b1;
      code_d  = emit_code;
    end else if (valid_q && event_ready_i) begin
      valid_d = 1'b0;
    end
    if (emit && !load) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_HOLD_OFF;
      presc_q   <= '0;
      ms_cnt_q  <= '0;
      valid_q   <= 1'b0;
      code_q    <= 2'b00;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      ms_cnt_q  <= ms_cnt_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      overrun_q <= overrun_d;
    end
  end

  assign event_valid_o = valid_q;
  assign event_code_o  = code_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb/tb_button_event_ctrl.sv - directed self-checking bench for button_event_ctrl
module tb_button_event_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_i;
  logic       event_valid_o;
  logic [1:0] event_code_o;
  logic       event_ready_i;
  logic       overrun_o;

  int passed = 0;
  int total  = 0;
  int hs_count = 0;
  logic [1:0] last_code = 2'b00;
  logic       seen_double = 1'b0;

`ifdef BTN_EVENT_DOUBLE_EN
  localparam int SHORT_LAT = 3000;
`else
  localparam int SHORT_LAT = 0;
`endif

  button_event_ctrl #(
    .clock_freq     (1_000_000),
    .long_press_ms  (10),
    .double_click_ms(3),
    .initial_value  (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_i        (btn_i),
    .event_valid_o(event_valid_o),
    .event_code_o (event_code_o),
    .event_ready_i(event_ready_i),
    .overrun_o    (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor; only meaningful while ready is held constant across edges.
  always @(negedge clk) begin
    if (event_valid_o && event_ready_i) begin
      hs_count++;
      last_code = event_code_o;
      if (event_code_o == 2'b11) seen_double = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(output int n, input int limit);
    n = 0;
    while (!event_valid_o && n < limit) begin
      tick(1);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; btn_i = 1'b0; event_ready_i = 1'b1;
    tick(3);
    total++; if (event_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", event_valid_o); else passed++;
    total++; if (event_code_o !== 2'b00) $display("FAIL reset_code: got %b want 00", event_code_o); else passed++;
    total++; if (overrun_o !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun_o); else passed++;
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_short;
    int n, base;
    base = hs_count;
    btn_i = 1'b1; tick(1); tick(4999);
    btn_i = 1'b0; tick(1);
    wait_valid(n, 5000);
    total++; if (n != SHORT_LAT) $display("FAIL short_latency: got %0d want %0d", n, SHORT_LAT); else passed++;
    total++; if (event_code_o !== 2'b01) $display("FAIL short_code: got %b want 01", event_code_o); else passed++;
    tick(1);
    total++; if (event_valid_o !== 1'b0) $display("FAIL short_one_cycle: got %b want 0", event_valid_o); else passed++;
    tick(10000 - SHORT_LAT - 2);
    total++; if (hs_count - base != 1) $display("FAIL short_count: got %0d want 1", hs_count - base); else passed++;
  endtask

  task automatic test_long;
    int n, base;
    base = hs_count;
    btn_i = 1'b1; tick(1);
    wait_valid(n, 20000);
    total++; if (n != 10000) $display("FAIL long_latency: got %0d want 10000", n); else passed++;
    total++; if (event_code_o !== 2'b10) $display("FAIL long_code: got %b want 10", event_code_o); else passed++;
    tick(4999);
    btn_i = 1'b0; tick(1); tick(5000);
    total++; if (hs_count - base != 1) $display("FAIL long_count: got %0d want 1", hs_count - base); else passed++;
  endtask

  task automatic test_double;
    int n, base;
    base = hs_count;
    seen_double = 1'b0;
    btn_i = 1'b1; tick(2000);
    btn_i = 1'b0; tick(1000);
    btn_i = 1'b1; tick(2000);
    btn_i = 1'b0; tick(1);
`ifdef BTN_EVENT_DOUBLE_EN
    wait_valid(n, 5000);
    total++; if (n != 0) $display("FAIL double_latency: got %0d want 0", n); else passed++;
    total++; if (event_code_o !== 2'b11) $display("FAIL double_code: got %b want 11", event_code_o); else passed++;
    tick(5000);
    total++; if (hs_count - base != 1) $display("FAIL double_count: got %0d want 1", hs_count - base); else passed++;
    total++; if (seen_double !== 1'b1) $display("FAIL double_seen: got %b want 1", seen_double); else passed++;
`else
    wait_valid(n, 5000);
    total++; if (n != 0) $display("FAIL nodbl_latency: got %0d want 0", n); else passed++;
    tick(5000);
    total++; if (hs_count - base != 2) $display("FAIL nodbl_count: got %0d want 2", hs_count - base); else passed++;
    total++; if (last_code !== 2'b01) $display("FAIL nodbl_code: got %b want 01", last_code); else passed++;
    total++; if (seen_double !== 1'b0) $display("FAIL nodbl_no_double: got %b want 0", seen_double); else passed++;
`endif
  endtask

  task automatic test_backpressure;
    int n;
    event_ready_i = 1'b0;
    btn_i = 1'b1; tick(1000);
    btn_i = 1'b0; tick(1);
    wait_valid(n, 5000);
    total++; if (n != SHORT_LAT) $display("FAIL bp_first_latency: got %0d want %0d", n, SHORT_LAT); else passed++;
    total++; if (overrun_o !== 1'b0) $display("FAIL bp_overrun_early: got %b want 0", overrun_o); else passed++;
    btn_i = 1'b1; tick(1000);
    btn_i = 1'b0; tick(1); tick(4000);
    total++; if (event_valid_o !== 1'b1) $display("FAIL bp_held_valid: got %b want 1", event_valid_o); else passed++;
    total++; if (event_code_o !== 2'b01) $display("FAIL bp_held_code: got %b want 01", event_code_o); else passed++;
    total++; if (overrun_o !== 1'b1) $display("FAIL bp_overrun: got %b want 1", overrun_o); else passed++;
    event_ready_i = 1'b1; tick(1);
    total++; if (event_valid_o !== 1'b0) $display("FAIL bp_accept: got %b want 0", event_valid_o); else passed++;
    tick(3);
    total++; if (event_valid_o !== 1'b0) $display("FAIL bp_single_hs: got %b want 0", event_valid_o); else passed++;
    total++; if (overrun_o !== 1'b1) $display("FAIL bp_overrun_sticky: got %b want 1", overrun_o); else passed++;
  endtask

  task automatic test_reset_mid;
    int n, base;
    event_ready_i = 1'b1;
    btn_i = 1'b1; tick(1); tick(5000);
    rst = 1'b1; tick(1);
    total++; if (event_valid_o !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", event_valid_o); else passed++;
    total++; if (event_code_o !== 2'b00) $display("FAIL rst_mid_code: got %b want 00", event_code_o); else passed++;
    total++; if (overrun_o !== 1'b0) $display("FAIL rst_mid_overrun: got %b want 0", overrun_o); else passed++;
    tick(2);
    rst = 1'b0;
    base = hs_count;
    tick(12000);
    total++; if (hs_count - base != 0) $display("FAIL rst_hold_off: got %0d want 0", hs_count - base); else passed++;
    btn_i = 1'b0; tick(4000);
    total++; if (hs_count - base != 0) $display("FAIL rst_release: got %0d want 0", hs_count - base); else passed++;
    btn_i = 1'b1; tick(1); tick(4999);
    btn_i = 1'b0; tick(1);
    wait_valid(n, 5000);
    total++; if (n != SHORT_LAT) $display("FAIL rst_after_latency: got %0d want %0d", n, SHORT_LAT); else passed++;
    total++; if (event_code_o !== 2'b01) $display("FAIL rst_after_code: got %b want 01", event_code_o); else passed++;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_double();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
